// File: rtl/uart_rx_mon_pkg.sv
// Shared types for the multi-channel UART receive monitor: per-lane FSM states and the FIFO entry.
// Field widths are sized for the largest legal configuration; the top trims them to its parameters.
package uart_rx_mon_pkg;

    localparam int MAX_DATA_BITS = 8;
    localparam int MAX_CH_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    typedef struct packed {
        logic [MAX_CH_W-1:0]      ch;
        logic [MAX_DATA_BITS-1:0] data;
        logic                     perr;
        logic                     ferr;
    } fifo_entry_t;

endpackage

// File: rtl/uart_rx_mon_ch.sv
// One UART RX lane: 2-flop sync, frame FSM, one-entry holding register loaded on the last stop sample.
// i_take empties the hold; a frame completing into a full, un-taken hold is dropped and flagged on o_drop.
module uart_rx_mon_ch
    import uart_rx_mon_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    input  logic                 i_take,
    output logic                 o_hold_vld,
    output logic [DATA_BITS-1:0] o_hold_data,
    output logic                 o_hold_perr,
    output logic                 o_hold_ferr,
    output logic                 o_drop
);
    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    B_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    B_STOP = 3'(STOP_BITS - 1);

    logic [1:0]           r_sync;
    rx_state_t            r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 w_line, w_done, w_perr_fin;
    logic                 r_hold_vld, r_hold_perr, r_hold_ferr;
    logic [DATA_BITS-1:0] r_hold_data;

    assign w_line = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_ferr_nxt  = r_ferr;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_line) begin
                    w_state_nxt = ST_START;
                    w_bit_nxt   = '0;
                    w_ferr_nxt  = 1'b0;
                end
            end
            ST_START: begin
                // Start bit must still be low at its centre, otherwise it was a glitch
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_line, r_shift[DATA_BITS-1:1]};
                    if (r_bit == B_DATA) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_line;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt  = '0;
                    w_ferr_nxt = r_ferr | ~w_line;
                    if (r_bit == B_STOP) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_perr_fin = (PARITY_EN != 0) && ((^r_shift ^ r_par) != (PARITY_ODD != 0));

    // A take on the same edge frees the slot for the completing frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_hold_perr <= 1'b0;
            r_hold_ferr <= 1'b0;
        end else begin
            if (i_take) begin
                r_hold_vld <= 1'b0;
            end
            if (w_done && (!r_hold_vld || i_take)) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= r_shift;
                r_hold_perr <= w_perr_fin;
                r_hold_ferr <= w_ferr_nxt;
            end
        end
    end

    assign o_drop      = w_done && r_hold_vld && !i_take;
    assign o_hold_vld  = r_hold_vld;
    assign o_hold_data = r_hold_data;
    assign o_hold_perr = r_hold_perr;
    assign o_hold_ferr = r_hold_ferr;

endmodule

// File: rtl/uart_rx_mon.sv
// Multi-channel UART RX monitor: per-lane receivers, round-robin merge into one FIFO with valid/ready output.
// Hold loaded at T reaches the FIFO at T+1; no grant while FIFO full, so lanes overrun under backpressure.
module uart_rx_mon
    import uart_rx_mon_pkg::*;
#(
    parameter int   NUM_CH       = 2,
    parameter int   DATA_BITS    = 8,
    parameter int   PARITY_EN    = 0,
    parameter int   PARITY_ODD   = 0,
    parameter int   STOP_BITS    = 1,
    parameter int   CLKS_PER_BIT = 32,
    parameter int   FIFO_DEPTH   = 8,
    localparam int  CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    rx_i,
    input  logic                 clr_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_BITS-1:0] m_data_o,
    output logic [CH_W-1:0]      m_ch_o,
    output logic                 m_perr_o,
    output logic                 m_ferr_o,
    output logic [NUM_CH-1:0]    overrun_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0]    w_hold_vld, w_hold_perr, w_hold_ferr, w_drop, w_take;
    logic [DATA_BITS-1:0] w_hold_data [NUM_CH];
    logic [CH_W-1:0]      r_last, w_gnt_ch, w_idx;
    logic                 w_gnt_vld, w_push, w_pop, w_empty, w_full, w_unused_head;
    logic [AW:0]          r_wr_ptr, r_rd_ptr;
    logic [NUM_CH-1:0]    r_overrun;
    fifo_entry_t          r_mem [FIFO_DEPTH];
    fifo_entry_t          w_entry, w_head;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        uart_rx_mon_ch #(
            .DATA_BITS   (DATA_BITS),
            .PARITY_EN   (PARITY_EN),
            .PARITY_ODD  (PARITY_ODD),
            .STOP_BITS   (STOP_BITS),
            .CLKS_PER_BIT(CLKS_PER_BIT)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_rx       (rx_i[g]),
            .i_take     (w_take[g]),
            .o_hold_vld (w_hold_vld[g]),
            .o_hold_data(w_hold_data[g]),
            .o_hold_perr(w_hold_perr[g]),
            .o_hold_ferr(w_hold_ferr[g]),
            .o_drop     (w_drop[g])
        );
    end

    // Search starts one past the last grant; walking downwards lets the nearest requester win
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = CH_W'((int'(r_last) + i) % NUM_CH);
            if (w_hold_vld[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_idx;
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = w_gnt_vld && !w_full;
    assign w_pop   = m_valid_o && m_ready_i;
    assign w_take  = w_push ? (NUM_CH'(1) << w_gnt_ch) : '0;

    always_comb begin
        w_entry      = '0;
        w_entry.ch   = MAX_CH_W'(w_gnt_ch);
        w_entry.data = MAX_DATA_BITS'(w_hold_data[w_gnt_ch]);
        w_entry.perr = w_hold_perr[w_gnt_ch];
        w_entry.ferr = w_hold_ferr[w_gnt_ch];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_last    <= '0;
            r_overrun <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_last   <= w_gnt_ch;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A drop on the clearing edge keeps its flag
            r_overrun <= (r_overrun & {NUM_CH{~clr_i}}) | w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign w_unused_head = ^w_head;

    assign m_valid_o = !w_empty;
    assign m_data_o  = m_valid_o ? w_head.data[DATA_BITS-1:0] : '0;
    assign m_ch_o    = m_valid_o ? w_head.ch[CH_W-1:0] : '0;
    assign m_perr_o  = m_valid_o && w_head.perr;
    assign m_ferr_o  = m_valid_o && w_head.ferr;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_uart_rx_mon.sv
// Bench for uart_rx_mon: an 8N1 instance and an 8E1 instance, directed frames, queued expectations
// checked by a monitor process on every accepted output entry.
module tb_uart_rx_mon;
    localparam int CPB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx00 = 1'b1, rx01 = 1'b1, rx10 = 1'b1, rx11 = 1'b1;
    logic clr0 = 1'b0, clr1 = 1'b0, ready0 = 1'b1, ready1 = 1'b1;

    logic       m_valid0, m_perr0, m_ferr0, m_valid1, m_perr1, m_ferr1;
    logic [7:0] m_data0, m_data1;
    logic [0:0] m_ch0, m_ch1;
    logic [1:0] ovr0, ovr1;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_mon #(.NUM_CH(2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                  .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .rst(rst), .rx_i({rx01, rx00}), .clr_i(clr0),
        .m_valid_o(m_valid0), .m_ready_i(ready0), .m_data_o(m_data0), .m_ch_o(m_ch0),
        .m_perr_o(m_perr0), .m_ferr_o(m_ferr0), .overrun_o(ovr0)
    );

    uart_rx_mon #(.NUM_CH(2), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                  .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .rx_i({rx11, rx10}), .clr_i(clr1),
        .m_valid_o(m_valid1), .m_ready_i(ready1), .m_data_o(m_data1), .m_ch_o(m_ch1),
        .m_perr_o(m_perr1), .m_ferr_o(m_ferr1), .overrun_o(ovr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic score(input int inst, input logic [10:0] act);
        logic [10:0] e;
        n_checks++;
        if ((inst == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_fail++;
            $display("FAIL dut%0d_unexpected_entry: got %h, none expected", inst, act);
        end else begin
            e = (inst == 0) ? q0.pop_front() : q1.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL dut%0d_entry: got %h expected %h", inst, act, e);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (m_valid0 && ready0) score(0, {m_ch0, m_data0, m_perr0, m_ferr0});
            if (m_valid1 && ready1) score(1, {m_ch1, m_data1, m_perr1, m_ferr1});
        end
    endtask

    task automatic drive(input int inst, input int ch, input logic v);
        if (inst == 0 && ch == 0)      rx00 = v;
        else if (inst == 0)            rx01 = v;
        else if (ch == 0)              rx10 = v;
        else                           rx11 = v;
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with the line idle
    task automatic send_frame(input int inst, input int ch, input logic [7:0] d,
                              input logic par, input logic stop_v);
        logic [10:0] bits;
        int n;
        if (inst == 1) begin
            bits = {stop_v, par, d, 1'b0};
            n = 11;
        end else begin
            bits = {1'b1, stop_v, d, 1'b0};
            n = 10;
        end
        for (int b = 0; b < n; b++) begin
            drive(inst, ch, bits[b]);
            if (b == n - 1 && !bits[b]) begin
                // Low stop bit released soon after its centre so it is not mistaken for a new start
                repeat (CPB * 3 / 4) @(posedge clk);
                #1 drive(inst, ch, 1'b1);
                repeat (CPB / 4) @(posedge clk);
            end else begin
                repeat (CPB) @(posedge clk);
            end
            #1;
        end
        drive(inst, ch, 1'b1);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (4) @(posedge clk);
        #1;
        chk("reset_valid0", m_valid0, 1'b0);
        chk("reset_data0", m_data0, 8'h00);
        chk("reset_ch0", m_ch0, 1'b0);
        chk("reset_perr_ferr0", {m_perr0, m_ferr0}, 2'b00);
        chk("reset_overrun0", ovr0, 2'b00);
        chk("reset_valid1", m_valid1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic 8N1 frame and output latency
        ready0 = 1'b0;
        q0.push_back({1'b0, 8'h55, 2'b00});
        send_frame(0, 0, 8'h55, 1'b0, 1'b1);
        chk("latency_valid", m_valid0, 1'b1);
        ready0 = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Framing error followed by a clean frame
        q0.push_back({1'b0, 8'h0F, 2'b01});
        send_frame(0, 0, 8'h0F, 1'b0, 1'b0);
        repeat (CPB) @(posedge clk);
        #1;
        q0.push_back({1'b0, 8'h10, 2'b00});
        send_frame(0, 0, 8'h10, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // Simultaneous completion: last grant was ch0, so ch1 goes first
        q0.push_back({1'b1, 8'h22, 2'b00});
        q0.push_back({1'b0, 8'h11, 2'b00});
        fork
            send_frame(0, 0, 8'h11, 1'b0, 1'b1);
            send_frame(0, 1, 8'h22, 1'b0, 1'b1);
        join
        repeat (5) @(posedge clk);
        #1;

        // Short low glitch on ch1
        drive(0, 1, 1'b0);
        repeat (5) @(posedge clk);
        #1 drive(0, 1, 1'b1);
        repeat (2 * CPB) @(posedge clk);
        #1;
        chk("glitch_no_valid", m_valid0, 1'b0);

        // Backpressure: 8 fill the FIFO, 1 waits in the hold, 3 are dropped
        ready0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 9) q0.push_back({1'b0, 8'(8'h30 + i), 2'b00});
            send_frame(0, 0, 8'(8'h30 + i), 1'b0, 1'b1);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("overrun_set", ovr0, 2'b01);
        chk("full_valid", m_valid0, 1'b1);
        clr0 = 1'b1;
        @(posedge clk);
        #1 clr0 = 1'b0;
        chk("overrun_clear", ovr0, 2'b00);
        ready0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_count", q0.size(), 0);
        chk("drain_empty", m_valid0, 1'b0);

        // Reset with an entry queued and a frame in flight
        ready0 = 1'b0;
        send_frame(0, 0, 8'hA5, 1'b0, 1'b1);
        drive(0, 0, 1'b0);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 drive(0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_valid", m_valid0, 1'b0);
        chk("midreset_data", m_data0, 8'h00);
        chk("midreset_fields", {m_ch0, m_perr0, m_ferr0, ovr0}, 5'b0);
        rst = 1'b0;
        ready0 = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("after_reset_no_entry", m_valid0, 1'b0);
        q0.push_back({1'b0, 8'h3C, 2'b00});
        send_frame(0, 0, 8'h3C, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // Even parity instance
        q1.push_back({1'b1, 8'hA3, 2'b10});
        send_frame(1, 1, 8'hA3, 1'b1, 1'b1);
        q1.push_back({1'b1, 8'hA3, 2'b00});
        send_frame(1, 1, 8'hA3, 1'b0, 1'b1);
        q1.push_back({1'b0, 8'h07, 2'b00});
        send_frame(1, 0, 8'h07, 1'b1, 1'b1);
        q1.push_back({1'b0, 8'h07, 2'b10});
        send_frame(1, 0, 8'h07, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        chk("q0_all_seen", q0.size(), 0);
        chk("q1_all_seen", q1.size(), 0);
        chk("overrun1_idle", ovr1, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_mon.md
UART_RX_MON -- requirements
Module: uart_rx_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent UART RX lines monitored.
REQ-002 SHALL have parameter DATA_BITS, default 8, legal 5..8, data bits per frame, LSB first.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = one parity bit follows data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have parameter CLKS_PER_BIT, default 32 (25 MHz / 781250 Bd), legal >= 4.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2.
REQ-008 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-009 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-010 SHALL have port rx_i  in  NUM_CH  asynchronous serial lines, idle high.
REQ-011 SHALL have port clr_i  in  1  synchronous clear of sticky overrun flags.
REQ-012 SHALL have port m_valid_o  out  1  output entry available.
REQ-013 SHALL have port m_ready_i  in  1  consumer accepts entry when high with m_valid_o.
REQ-014 SHALL have port m_data_o  out  DATA_BITS  received character.
REQ-015 SHALL have port m_ch_o  out  max(1,clog2(NUM_CH))  source channel index.
REQ-016 SHALL have port m_perr_o  out  1  parity mismatch on this frame; always 0 when PARITY_EN=0.
REQ-017 SHALL have port m_ferr_o  out  1  any stop bit sampled low.
REQ-018 SHALL have port overrun_o  out  NUM_CH  sticky per-channel dropped-frame flag.

Function
REQ-019 Each rx_i bit SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-020 Per-channel FSM states SHALL be IDLE, START, DATA, PARITY, STOP; bit counter counts 0..CLKS_PER_BIT-1.
REQ-021 IDLE -> START when synchronized line low; counter cleared.
REQ-022 START: at count CLKS_PER_BIT/2-1, line low -> DATA with counter 0; line high -> IDLE (glitch, nothing recorded).
REQ-023 DATA/PARITY/STOP SHALL sample at count CLKS_PER_BIT-1 (mid-bit), then restart counter.
REQ-024 After DATA_BITS samples -> PARITY if PARITY_EN else STOP; after parity sample -> STOP.
REQ-025 perr = XOR(data, parity bit) != PARITY_ODD; ferr = OR over STOP_BITS samples of (sample==0).
REQ-026 On the last stop sample edge the frame SHALL load the channel's one-entry holding register and FSM -> IDLE; IDLE may restart immediately if line low.
REQ-027 If the holding register is still full at that edge, the new frame SHALL be dropped and overrun_o[ch] set.
REQ-028 Round-robin arbiter SHALL move at most one holding register per cycle into the shared FIFO, starting search after last granted channel; no grant while FIFO full.
REQ-029 m_valid_o SHALL equal FIFO not empty; m_* fields show the FIFO head combinationally.
REQ-030 Latency: holding register loaded at edge T, FIFO written at T+1, m_valid_o high after T+1 when FIFO was empty and channel won arbitration.
REQ-031 Pop occurs on m_valid_o && m_ready_i; when full, space freed by a pop SHALL be usable from the next cycle only.
REQ-032 Simultaneous push and pop on non-full, non-empty FIFO SHALL keep occupancy constant.
REQ-033 clr_i SHALL clear overrun_o; an overrun on the same edge as clr_i SHALL win (flag set).

Reset
REQ-034 rst SHALL force FSMs IDLE, counters 0, synchronizers 1, holding registers empty, FIFO empty, arbiter pointer 0.
REQ-035 During and after reset m_valid_o=0, m_data_o=0, m_ch_o=0, m_perr_o=0, m_ferr_o=0, overrun_o=0.
REQ-036 Reset mid-frame SHALL discard the partial frame; first frame recorded is one whose start edge follows reset release.

Structure
REQ-037 Shared package uart_rx_mon_pkg SHALL hold the FSM state enum and the FIFO entry struct {ch, data, perr, ferr}.
REQ-038 Per-channel synchronizer, FSM and holding register SHALL be sub-module uart_rx_mon_ch, instantiated NUM_CH times.

Verification
REQ-039 Ch0 sends 0x55 8N1 at 32 clk/bit -> one entry data=0x55 ch=0 perr=0 ferr=0, m_valid_o within 2 bit times of stop-bit centre.
REQ-040 PARITY_EN=1 even, ch1 sends 0xA3 with parity bit 1 -> data=0xA3 perr=1; with parity 0 -> perr=0.
REQ-041 Ch0 sends 0x0F with stop bit forced low -> ferr=1; next frame 0x10 received correctly.
REQ-042 Both channels finish frames 0x11/0x22 on same edge -> two entries, order set by arbiter pointer, none lost.
REQ-043 m_ready_i=0, 12 frames on ch0 (FIFO_DEPTH 8) -> 8 in FIFO, 1 held, overrun_o[0]=1; clr_i clears it; draining yields 9 entries in order.
REQ-044 5-clk low glitch on ch1 -> no entry; rst asserted mid-frame -> no entry, outputs at reset values.
